spi_agc_ctrl: RTL and testbench
===============================

// Module: spi_agc_ctrl
// PURPOSE
//  Parametrised successor to the two-channel AGC/detector SPI front end. Drives NUM_CH
//  chip selects over one shared 3-wire SPI bus (sclk plus bidirectional sdio), with a
//  configurable frame format and sclk divider. Also provides a registered parallel-pin
//  mode that forwards per-channel gain words. Sits between the AXI register block and
//  the IOBUF/pin layer.
// PARAMETERS
//  NUM_CH   2   number of slave channels; CH_W = (NUM_CH>1) ? $clog2(NUM_CH) : 1
//  ADDR_W   7   address bits per frame
//  DATA_W   8   data bits per frame; FRAME_LEN = 1 + ADDR_W + DATA_W
//  CLK_DIV  4   main_clk cycles per sclk half-period, >= 1
//  PAR_W    6   parallel gain-pin width per channel
// PORTS
//  main_clk  in   1             system clock
//  reset     in   1             async active-high reset
//  mode      in   2             00 idle, 01 SPI, 10 parallel, 11 treated as 00
//  start     in   1             one-cycle transfer request
//  ch_sel    in   CH_W          target channel
//  rw        in   1             1 = read, 0 = write
//  addr      in   ADDR_W        register address
//  wdata     in   DATA_W        write data
//  rdata     out  DATA_W        read data, valid when done pulses
//  busy      out  1             transfer in progress
//  done      out  1             one-cycle end-of-transfer pulse
//  err       out  1             one-cycle pulse: start rejected because ch_sel >= NUM_CH
//  cs_n      out  NUM_CH        active-low chip selects
//  sclk      out  1             SPI clock, idles low
//  sdio_o    out  1             sdio drive value (to IOBUF I)
//  sdio_t    out  1             1 = tristate/receive (to IOBUF T)
//  sdio_i    in   1             sdio receive value (from IOBUF O)
//  par_data  in   NUM_CH*PAR_W  parallel gain words, ch0 in LSBs
//  par_out   out  NUM_CH*PAR_W  registered parallel pins
// BEHAVIOUR
//  - Reset (async): cs_n all 1, sclk 0, sdio_o 0, sdio_t 1, busy/done/err 0, rdata 0,
//    par_out 0, FSM in IDLE. A reset during a transfer aborts it at once; nothing resumes.
//  - All outputs are registered.
//  - FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
//  - Start acceptance: start is taken only in IDLE with mode==01. At that point ch_sel,
//    rw, addr and wdata are latched into the frame {rw, addr, wdata}, sent MSB first.
//    start is ignored while busy, or when mode!=01.
//  - Bad channel: ch_sel >= NUM_CH gives err=1 for one cycle. No cs_n toggles and the
//    FSM stays in IDLE.
//  - SETUP (CLK_DIV cycles): busy=1, selected cs_n=0, sclk=0, sdio_t=0, sdio_o=frame MSB.
//  - SHIFT: each of the FRAME_LEN bits spends CLK_DIV cycles with sclk low, then CLK_DIV
//    cycles with sclk high.
//    - sdio_o changes only on sclk falling edges.
//    - Rising edges are the sample points.
//  - Read turnaround: sdio_t goes to 1 at the falling edge after the last address bit.
//    sdio_i is shifted into rdata on each of the following DATA_W rising edges, MSB first.
//  - HOLD (CLK_DIV cycles, sclk 0): then cs_n all 1, busy=0, sdio_t=1, done=1 in the
//    same cycle.
//  - Latency: done occurs at cycle T+1+CLK_DIV*(2*FRAME_LEN+2), where T is the start
//    cycle. The next start is accepted in the cycle after done.
//  - Mode changes mid-transfer are ignored until IDLE.
//  - Parallel mode (mode==10): par_out <= par_data every cycle, i.e. one-cycle latency.
//    cs_n all 1, sclk 0, sdio_t 1. start is ignored.
//  - Other modes: par_out holds its last value; SPI pins keep their idle values.
// CONFIGURATION
//  SPI_AGC_READBACK_EN defined: read frames behave as described above.
//  Not defined:
//    - rw is treated as 0 (write only).
//    - sdio_t=0 for the whole of SETUP through HOLD.
//    - rdata is tied to 0.
// TESTING (NUM_CH=3, ADDR_W=7, DATA_W=8, CLK_DIV=2, so FRAME_LEN=16)
//  1. Write: mode=01, ch_sel=2, addr=0x05, wdata=0xA3 -> cs_n=3'b011, 16 sclk rising
//     edges, sdio bits 0_0000101_10100011, done at T+69, no other cs_n activity.
//  2. Read (READBACK_EN): ch_sel=0, addr=0x12, model drives 0x5C -> sdio_t=1 after the
//     8th falling edge, rdata=0x5C with done at T+69.
//  3. Bad channel: ch_sel=3 -> err pulse at T+1, cs_n stays 3'b111, busy stays 0.
//  4. Parallel mode: mode=10, par_data=18'h2A5C3 -> par_out=18'h2A5C3 one cycle later;
//     start pulses produce no sclk.
//  5. Reset mid-frame: reset asserted at the 5th rising edge -> cs_n=111, sclk=0,
//     busy=0 immediately; after release, a new write completes with done at T+69.
//  6. Collisions: start, plus a mode change to 10, while busy -> both ignored; the
//     frame and done timing are unchanged.

Source files
------------

// File: rtl/spi_agc_ctrl.sv
// NUM_CH-channel 3-wire SPI master with a registered parallel gain-pin mode.
// Optional read turnaround and readback are enabled by defining SPI_AGC_READBACK_EN.
module spi_agc_ctrl #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int PAR_W   = 6,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    main_clk,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic                    start,
    input  logic [CH_W-1:0]         ch_sel,
    input  logic                    rw,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [NUM_CH-1:0]       cs_n,
    output logic                    sclk,
    output logic                    sdio_o,
    output logic                    sdio_t,
    input  logic                    sdio_i,
    input  logic [NUM_CH*PAR_W-1:0] par_data,
    output logic [NUM_CH*PAR_W-1:0] par_out
);

    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int BIT_W     = $clog2(FRAME_LEN);
    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic                   phase_q, phase_d;
    logic [FRAME_LEN-1:0]   frame_q, frame_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic                   rd_q, rd_d;
    logic [DATA_W-1:0]      rx_q, rx_d;
    logic                   reject;
    logic                   rw_eff;
    logic                   ch_ok;
    logic                   div_last;

    logic [NUM_CH-1:0]       cs_n_d;
    logic                    sclk_d, sdio_o_d, sdio_t_d;
    logic                    busy_d, done_d, err_d;
    logic [DATA_W-1:0]       rdata_d;
    logic [NUM_CH*PAR_W-1:0] par_out_d;

`ifdef SPI_AGC_READBACK_EN
    assign rw_eff = rw;
`else
    assign rw_eff = 1'b0 & rw;
`endif

    assign ch_ok    = int'(ch_sel) < NUM_CH;
    assign div_last = (div_q == DIV_LAST);

    // State and datapath registers
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            frame_q <= '0;
            ch_q    <= '0;
            rd_q    <= 1'b0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            frame_q <= frame_d;
            ch_q    <= ch_d;
            rd_q    <= rd_d;
            rx_q    <= rx_d;
        end
    end

    // Next-state logic; mode and start are only looked at in IDLE
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        frame_d = frame_q;
        ch_d    = ch_q;
        rd_d    = rd_q;
        rx_d    = rx_q;
        reject  = 1'b0;
        unique case (state_q)
            IDLE: begin
                div_d   = '0;
                bit_d   = '0;
                phase_d = 1'b0;
                if (mode == 2'b01 && start) begin
                    if (ch_ok) begin
                        state_d = SETUP;
                        frame_d = {rw_eff, addr, wdata};
                        ch_d    = ch_sel;
                        rd_d    = rw_eff;
                        rx_d    = '0;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT: begin
                if (!div_last) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        if (rd_q && int'(bit_q) > ADDR_W)
                            rx_d = (rx_q << 1) | DATA_W'(sdio_i);
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == BIT_LAST)
                            state_d = HOLD;
                        else
                            bit_d = bit_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from next-state values so every pin leaves a flop
    always_comb begin
        cs_n_d    = '1;
        sclk_d    = 1'b0;
        sdio_o_d  = 1'b0;
        sdio_t_d  = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = reject;
        rdata_d   = rdata;
        par_out_d = par_out;
        if (state_d != IDLE) begin
            busy_d = 1'b1;
            for (int unsigned i = 0; i < NUM_CH; i++)
                if (ch_d == CH_W'(i))
                    cs_n_d[i] = 1'b0;
            sclk_d   = (state_d == SHIFT) && phase_d;
            sdio_o_d = frame_d[BIT_LAST - bit_d];
            sdio_t_d = rd_d && (state_d == HOLD || int'(bit_d) > ADDR_W);
        end
        if (state_q != IDLE && state_d == IDLE) begin
            done_d = 1'b1;
            if (rd_q)
                rdata_d = rx_q;
        end
        if (state_q == IDLE && mode == 2'b10)
            par_out_d = par_data;
    end

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            cs_n    <= '1;
            sclk    <= 1'b0;
            sdio_o  <= 1'b0;
            sdio_t  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            par_out <= '0;
        end else begin
            cs_n    <= cs_n_d;
            sclk    <= sclk_d;
            sdio_o  <= sdio_o_d;
            sdio_t  <= sdio_t_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            rdata   <= rdata_d;
            par_out <= par_out_d;
        end
    end

endmodule

// File: tb/tb_spi_agc_ctrl.sv
// Directed bench for spi_agc_ctrl: NUM_CH=3, ADDR_W=7, DATA_W=8, CLK_DIV=2, PAR_W=6.
module tb_spi_agc_ctrl;

`ifdef SPI_AGC_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int LAT = 69;

    logic        main_clk = 1'b0;
    logic        reset    = 1'b1;
    logic [1:0]  mode     = 2'b00;
    logic        start    = 1'b0;
    logic [1:0]  ch_sel   = '0;
    logic        rw       = 1'b0;
    logic [6:0]  addr     = '0;
    logic [7:0]  wdata    = '0;
    logic [7:0]  rdata;
    logic        busy, done, err;
    logic [2:0]  cs_n;
    logic        sclk, sdio_o, sdio_t;
    logic        sdio_i   = 1'b0;
    logic [17:0] par_data = '0;
    logic [17:0] par_out;

    spi_agc_ctrl #(
        .NUM_CH (3),
        .ADDR_W (7),
        .DATA_W (8),
        .CLK_DIV(2),
        .PAR_W  (6)
    ) dut (
        .main_clk(main_clk),
        .reset   (reset),
        .mode    (mode),
        .start   (start),
        .ch_sel  (ch_sel),
        .rw      (rw),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .cs_n    (cs_n),
        .sclk    (sclk),
        .sdio_o  (sdio_o),
        .sdio_t  (sdio_t),
        .sdio_i  (sdio_i),
        .par_data(par_data),
        .par_out (par_out)
    );

    always #5 main_clk = ~main_clk;

    int cyc = 0;
    always @(posedge main_clk) cyc++;

    int checks   = 0;
    int failures = 0;

    // Bus monitor and slave model, sampled on the inactive clock edge
    logic        sclk_prev  = 1'b0;
    int          rise_cnt   = 0;
    int          fall_cnt   = 0;
    int          cs_bad     = 0;
    int          err_cnt    = 0;
    logic [15:0] cap        = '0;
    logic        t_f7       = 1'b0;
    logic        t_f8       = 1'b0;
    logic [2:0]  exp_cs_mon = 3'b111;
    logic [7:0]  slave_word = '0;

    always @(negedge main_clk) begin
        if (sclk === 1'b1 && sclk_prev === 1'b0) begin
            cap = {cap[14:0], sdio_o};
            rise_cnt++;
        end
        if (sclk === 1'b0 && sclk_prev === 1'b1) begin
            fall_cnt++;
            if (fall_cnt == 7) t_f7 = sdio_t;
            if (fall_cnt == 8) t_f8 = sdio_t;
            if (fall_cnt >= 8 && fall_cnt <= 15) sdio_i = slave_word[15 - fall_cnt];
        end
        if (cs_n !== 3'b111 && cs_n !== exp_cs_mon) cs_bad++;
        if (err === 1'b1) err_cnt++;
        sclk_prev = sclk;
    end

    typedef struct {
        logic [1:0]  ch;
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  slave;
        logic        bad;
        logic [2:0]  exp_cs;
        logic [15:0] exp_frame;
        logic        exp_t8;
        logic        chk_rd;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(negedge main_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_xfer(input vec_t v, input bit collide, input string tag);
        int          t0;
        int          done_cyc;
        bit          got;
        bit          injected;
        logic [17:0] par_before;
        tick();
        par_before = par_out;
        mode       = 2'b01;
        ch_sel     = v.ch;
        rw         = v.rw;
        addr       = v.addr;
        wdata      = v.wdata;
        start      = 1'b1;
        rise_cnt   = 0;
        fall_cnt   = 0;
        cs_bad     = 0;
        err_cnt    = 0;
        cap        = '0;
        t_f7       = 1'b0;
        t_f8       = 1'b0;
        sdio_i     = 1'b0;
        exp_cs_mon = v.exp_cs;
        slave_word = v.slave;
        t0         = cyc;
        tick();
        start = 1'b0;
        if (v.bad) begin
            check({tag, " err_pulse"}, err, 1);
            check({tag, " busy_bad"}, busy, 0);
            check({tag, " cs_bad_ch"}, cs_n, 3'b111);
            repeat (10) tick();
            check({tag, " err_once"}, err_cnt, 1);
            check({tag, " no_sclk"}, rise_cnt, 0);
            check({tag, " cs_quiet"}, cs_bad, 0);
            check({tag, " busy_after"}, busy, 0);
            return;
        end
        check({tag, " busy_t1"}, busy, 1);
        check({tag, " cs_t1"}, cs_n, v.exp_cs);
        got      = 1'b0;
        injected = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (done === 1'b1) begin
                got      = 1'b1;
                done_cyc = cyc;
            end else begin
                if (collide && !injected && rise_cnt >= 3) begin
                    start    = 1'b1;
                    ch_sel   = 2'd0;
                    addr     = 7'h00;
                    mode     = 2'b10;
                    par_data = 18'h15555;
                    injected = 1'b1;
                end else if (start) begin
                    start = 1'b0;
                end
                if (collide && injected && rise_cnt >= 6) mode = 2'b01;
                tick();
            end
        end
        start = 1'b0;
        mode  = 2'b01;
        check({tag, " done_seen"}, got, 1);
        check({tag, " latency"}, done_cyc - t0, LAT);
        check({tag, " sclk_rises"}, rise_cnt, 16);
        check({tag, " frame"}, cap, v.exp_frame);
        check({tag, " cs_other"}, cs_bad, 0);
        check({tag, " no_err"}, err_cnt, 0);
        check({tag, " busy_done"}, busy, 0);
        check({tag, " cs_done"}, cs_n, 3'b111);
        check({tag, " sdio_t_done"}, sdio_t, 1);
        check({tag, " sdio_t_f7"}, t_f7, 0);
        check({tag, " sdio_t_f8"}, t_f8, v.exp_t8);
        if (v.chk_rd) check({tag, " rdata"}, rdata, v.exp_rdata);
        if (collide) check({tag, " par_held"}, par_out, par_before);
        tick();
        check({tag, " done_1cyc"}, done, 0);
    endtask

    initial begin
        vec_t coll;
        bit   hit;
        vecs[0] = '{2'd2, 1'b0, 7'h05, 8'hA3, 8'h00, 1'b0, 3'b011, 16'h05A3, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{2'd0, 1'b1, 7'h12, 8'h00, 8'h5C, 1'b0, 3'b110,
                    RB ? 16'h9200 : 16'h1200, RB, 1'b1, RB ? 8'h5C : 8'h00};
        vecs[2] = '{2'd3, 1'b0, 7'h05, 8'hA3, 8'h00, 1'b1, 3'b111, 16'h0000, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{2'd1, 1'b0, 7'h7F, 8'h00, 8'h00, 1'b0, 3'b101, 16'h7F00, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{2'd0, 1'b0, 7'h00, 8'hFF, 8'h00, 1'b0, 3'b110, 16'h00FF, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{2'd2, 1'b1, 7'h7F, 8'h00, 8'hA5, 1'b0, 3'b011,
                    RB ? 16'hFF00 : 16'h7F00, RB, 1'b1, RB ? 8'hA5 : 8'h00};
        coll    = '{2'd1, 1'b0, 7'h33, 8'h3C, 8'h00, 1'b0, 3'b101, 16'h333C, 1'b0, 1'b0, 8'h00};

        reset = 1'b1;
        repeat (3) tick();
        check("rst cs_n", cs_n, 3'b111);
        check("rst sclk", sclk, 0);
        check("rst sdio_o", sdio_o, 0);
        check("rst sdio_t", sdio_t, 1);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        check("rst rdata", rdata, 0);
        check("rst par_out", par_out, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            do_xfer(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Parallel mode: one-cycle latency, start ignored, value held outside mode 10
        tick();
        mode     = 2'b10;
        par_data = 18'h2A5C3;
        #1;
        check("par before edge", par_out, 0);
        tick();
        check("par latency", par_out, 18'h2A5C3);
        rise_cnt = 0;
        ch_sel   = 2'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("par no_sclk", rise_cnt, 0);
        check("par busy", busy, 0);
        check("par cs_n", cs_n, 3'b111);
        check("par sdio_t", sdio_t, 1);
        mode     = 2'b00;
        par_data = 18'h3FFFF;
        repeat (2) tick();
        check("par hold mode00", par_out, 18'h2A5C3);
        mode  = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("mode11 busy", busy, 0);
        check("mode11 par hold", par_out, 18'h2A5C3);

        do_xfer(coll, 1'b1, "collide");

        // Reset mid-frame, then a fresh write must complete normally
        tick();
        mode       = 2'b01;
        ch_sel     = 2'd2;
        rw         = 1'b0;
        addr       = 7'h05;
        wdata      = 8'hA3;
        exp_cs_mon = 3'b011;
        rise_cnt   = 0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        hit   = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (rise_cnt >= 5) hit = 1'b1;
            else tick();
        end
        check("midrst reached", hit, 1);
        reset = 1'b1;
        #1;
        check("midrst cs_n", cs_n, 3'b111);
        check("midrst sclk", sclk, 0);
        check("midrst busy", busy, 0);
        check("midrst sdio_t", sdio_t, 1);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("midrst no_resume", busy, 0);
        do_xfer(vecs[0], 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
